router_fsm: RTL and testbench

Control FSM of the 1x3 packet router. Watches the incoming packet stream and the three output FIFOs' status. Sequences header decode, first-data load, payload load, parity load and parity check. Emits Moore-style state strobes that drive the register block, synchronizer and write-enable logic.

---
 rtl/router_fsm.sv | 116 +++++++++++
 tb/tb_router_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - control FSM of the 1x3 packet router
// Sequences header decode, payload/parity load and parity check; Moore strobes out.
module router_fsm (
   input  logic       clk,
   input  logic       rstn,
   input  logic       pkt_valid,
   input  logic       parity_done,
   input  logic       sft_rst0,
   input  logic       sft_rst1,
   input  logic       sft_rst2,
   input  logic       fifo_full,
   input  logic       low_pkt_valid,
   input  logic       fifo_empty0,
   input  logic       fifo_empty1,
   input  logic       fifo_empty2,
   input  logic [1:0] data_in,
   output logic       busy,
   output logic       detect_add,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       lfd_state
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'b000,
      LOAD_FIRST_DATA    = 3'b001,
      LOAD_DATA          = 3'b010,
      LOAD_PARITY        = 3'b011,
      CHECK_PARITY_ERROR = 3'b100,
      FIFO_FULL_STATE    = 3'b101,
      LOAD_AFTER_FULL    = 3'b110,
      WAIT_TILL_EMPTY    = 3'b111
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic       hdr_empty;
   logic       latched_empty;
   logic       latched_sft_rst;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= DECODE_ADDRESS;
         addr_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Header byte selects its FIFO directly; later states use the latched address.
   always_comb begin
      hdr_empty       = 1'b0;
      latched_empty   = 1'b0;
      latched_sft_rst = 1'b0;
      case (data_in)
         2'd0:    hdr_empty = fifo_empty0;
         2'd1:    hdr_empty = fifo_empty1;
         2'd2:    hdr_empty = fifo_empty2;
         default: hdr_empty = 1'b0;
      endcase
      case (addr_q)
         2'd0:    begin latched_empty = fifo_empty0; latched_sft_rst = sft_rst0; end
         2'd1:    begin latched_empty = fifo_empty1; latched_sft_rst = sft_rst1; end
         2'd2:    begin latched_empty = fifo_empty2; latched_sft_rst = sft_rst2; end
         default: begin latched_empty = 1'b0;        latched_sft_rst = 1'b0;     end
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = data_in;
      case (state_q)
         DECODE_ADDRESS: begin
            if (pkt_valid && data_in != 2'd3)
               state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)        state_d = DECODE_ADDRESS;
            else if (low_pkt_valid) state_d = LOAD_PARITY;
            else                    state_d = LOAD_DATA;
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         WAIT_TILL_EMPTY: begin
            if (latched_empty) state_d = LOAD_FIRST_DATA;
         end
         default: state_d = DECODE_ADDRESS;
      endcase
      // Destination soft reset abandons the packet from any busy state.
      if (state_q != DECODE_ADDRESS && latched_sft_rst) state_d = DECODE_ADDRESS;
   end

   assign detect_add    = (state_q == DECODE_ADDRESS);
   assign lfd_state     = (state_q == LOAD_FIRST_DATA);
   assign ld_state      = (state_q == LOAD_DATA);
   assign full_state    = (state_q == FIFO_FULL_STATE);
   assign laf_state     = (state_q == LOAD_AFTER_FULL);
   assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                          (state_q == LOAD_AFTER_FULL);
   assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed and random bench for router_fsm
// Reference model tracks packet phase by name and derives strobes from phase sets.
module tb_router_fsm;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       pkt_valid = 1'b0, parity_done = 1'b0;
   logic       sft_rst0 = 1'b0, sft_rst1 = 1'b0, sft_rst2 = 1'b0;
   logic       fifo_full = 1'b0, low_pkt_valid = 1'b0;
   logic       fifo_empty0 = 1'b0, fifo_empty1 = 1'b0, fifo_empty2 = 1'b0;
   logic [1:0] data_in = 2'd0;
   logic       busy, detect_add, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, lfd_state;

   int n_cmp = 0;
   int n_bad = 0;

   typedef enum {P_IDLE, P_FIRST, P_BODY, P_PARITY, P_CHECK, P_STALL, P_RESUME, P_WAIT} phase_t;
   phase_t ph = P_IDLE;
   int     dest = 0;

   router_fsm dut (
      .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .parity_done(parity_done),
      .sft_rst0(sft_rst0), .sft_rst1(sft_rst1), .sft_rst2(sft_rst2),
      .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
      .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2),
      .data_in(data_in), .busy(busy), .detect_add(detect_add), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
      .rst_int_reg(rst_int_reg), .lfd_state(lfd_state)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] expect_outs(phase_t p);
      logic [7:0] v;
      v[7] = !(p inside {P_IDLE, P_BODY});
      v[6] = (p == P_IDLE);
      v[5] = (p == P_BODY);
      v[4] = (p == P_RESUME);
      v[3] = (p == P_STALL);
      v[2] = (p inside {P_BODY, P_PARITY, P_RESUME});
      v[1] = (p == P_CHECK);
      v[0] = (p == P_FIRST);
      return v;
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [2:0] empt, srst;
      phase_t     nx;
      empt = {fifo_empty2, fifo_empty1, fifo_empty0};
      srst = {sft_rst2, sft_rst1, sft_rst0};
      nx = ph;
      case (ph)
         P_IDLE:   if (pkt_valid && data_in < 3) nx = empt[data_in] ? P_FIRST : P_WAIT;
         P_FIRST:  nx = P_BODY;
         P_BODY:   nx = fifo_full ? P_STALL : (!pkt_valid ? P_PARITY : P_BODY);
         P_STALL:  nx = fifo_full ? P_STALL : P_RESUME;
         P_RESUME: nx = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_BODY);
         P_PARITY: nx = P_CHECK;
         P_CHECK:  nx = fifo_full ? P_STALL : P_IDLE;
         P_WAIT:   nx = (dest < 3 && empt[dest]) ? P_FIRST : P_WAIT;
      endcase
      if (ph != P_IDLE && dest < 3 && srst[dest]) nx = P_IDLE;
      if (ph == P_IDLE && pkt_valid) dest = int'(data_in);
      ph = nx;
   endtask

   task automatic check(string tag);
      logic [7:0] obs, exp_v;
      obs = {busy, detect_add, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, lfd_state};
      exp_v = expect_outs(ph);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: outs observed %b expected %b (phase %s)", tag, obs, exp_v, ph.name());
      end
   endtask

   task automatic tick(string tag);
      model_step();
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic clear_inputs();
      pkt_valid = 0; parity_done = 0; sft_rst0 = 0; sft_rst1 = 0; sft_rst2 = 0;
      fifo_full = 0; low_pkt_valid = 0; fifo_empty0 = 0; fifo_empty1 = 0; fifo_empty2 = 0;
      data_in = 2'd0;
   endtask

   task automatic async_reset(string tag);
      #2;
      rstn = 0;
      ph = P_IDLE;
      dest = 0;
      #1;
      check(tag);
      rstn = 1;
   endtask

   initial begin
      clear_inputs();
      rstn = 0;
      #3;
      check("reset_held");
      @(posedge clk); #1;
      check("reset_edge");
      rstn = 1;
      tick("reset_idle");

      // Normal packet to output 1
      pkt_valid = 1; data_in = 2'd1; fifo_empty1 = 1;
      tick("norm_lfd");
      tick("norm_ld1");
      tick("norm_ld2");
      pkt_valid = 0;
      tick("norm_parity");
      tick("norm_check");
      tick("norm_idle");

      // FIFO full mid-payload, resume and finish via low_pkt_valid
      pkt_valid = 1; data_in = 2'd0; fifo_empty0 = 1;
      tick("full_lfd");
      tick("full_ld");
      fifo_full = 1;
      tick("full_stall");
      tick("full_stall_hold");
      fifo_full = 0;
      tick("full_laf");
      low_pkt_valid = 0;
      tick("full_back_ld");
      fifo_full = 1;
      tick("full_stall2");
      fifo_full = 0;
      tick("full_laf2");
      low_pkt_valid = 1; pkt_valid = 0;
      tick("full_lp");
      low_pkt_valid = 0; fifo_full = 1;
      tick("full_check");
      tick("full_after_parity");
      fifo_full = 0;
      tick("full_laf3");
      parity_done = 1;
      tick("full_pd_idle");
      parity_done = 0;

      // Busy destination, then invalid address
      clear_inputs();
      pkt_valid = 1; data_in = 2'd2; fifo_empty2 = 0;
      tick("wait_enter");
      tick("wait_hold");
      fifo_empty2 = 1;
      tick("wait_lfd");
      pkt_valid = 0;
      tick("wait_ld");
      tick("wait_lp");
      tick("wait_check");
      tick("wait_idle");
      pkt_valid = 1; data_in = 2'd3;
      tick("addr3_stay");
      tick("addr3_stay2");

      // Soft reset: wrong output ignored, matching output aborts
      clear_inputs();
      pkt_valid = 1; data_in = 2'd1; fifo_empty1 = 1;
      tick("srst_lfd");
      tick("srst_ld");
      sft_rst0 = 1;
      tick("srst0_ignored");
      sft_rst0 = 0; sft_rst1 = 1;
      tick("srst1_abort");
      sft_rst1 = 0; pkt_valid = 0;
      tick("srst_idle");

      // Asynchronous reset mid-packet
      pkt_valid = 1; data_in = 2'd1;
      tick("arst_lfd");
      tick("arst_ld");
      async_reset("arst_immediate");
      pkt_valid = 0;
      tick("arst_after");

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         pkt_valid     = ($urandom_range(0, 3) != 0);
         parity_done   = ($urandom_range(0, 5) == 0);
         low_pkt_valid = ($urandom_range(0, 2) == 0);
         fifo_full     = ($urandom_range(0, 3) == 0);
         sft_rst0      = ($urandom_range(0, 29) == 0);
         sft_rst1      = ($urandom_range(0, 29) == 0);
         sft_rst2      = ($urandom_range(0, 29) == 0);
         fifo_empty0   = ($urandom_range(0, 2) != 0);
         fifo_empty1   = ($urandom_range(0, 2) != 0);
         fifo_empty2   = ($urandom_range(0, 2) != 0);
         data_in       = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 199) == 0) async_reset("rand_arst");
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
